// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter.
package period_meter_pkg;

   // Meter is either waiting for an arming edge or timing an interval.
   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } pm_state_t;

   localparam int PM_WIDTH = 24;

endpackage

// File: rtl/period_meter_sync2.sv
// Generic two-flop synchronizer with asynchronous active-low reset to 0.
// Kept free of meter-specific types so keypad and other slow inputs can reuse it.
module sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] s1;

   // First stage may go metastable; second stage gives it a full cycle to settle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= '0;
         q  <= '0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/period_meter.sv
// Half-period meter for a slow square wave. Reports N such that a divider
// toggling every N+1 cycles reproduces the input, with a one-cycle valid
// strobe and a sticky timeout when the input stops moving.
module period_meter
   import period_meter_pkg::*;
#(
   parameter int unsigned      WIDTH          = PM_WIDTH,
   parameter logic [WIDTH-1:0] TIMEOUT_CYCLES = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sig_in,
   output logic [WIDTH-1:0] half_period,
   output logic             valid,
   output logic             timeout
);

   logic             s2;
   logic             s_prev;
   logic             sig_edge;
   pm_state_t        state;
   logic [WIDTH-1:0] count;

   sync2 #(.W(1)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (sig_in),
      .q     (s2)
   );

   // Both polarities of transition are of interest.
   assign sig_edge = s2 ^ s_prev;

   // Edge history, arm/measure FSM, interval counter and output registers.
   // The first edge after reset or timeout only arms; later edges capture.
   // A capture edge takes priority over a timeout landing in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_prev      <= 1'b0;
         state       <= IDLE;
         count       <= '0;
         half_period <= '0;
         valid       <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         s_prev <= s2;
         valid  <= 1'b0;
         case (state)
            IDLE: begin
               count <= '0;
               if (sig_edge) state <= MEASURE;
            end
            MEASURE: begin
               if (sig_edge) begin
                  half_period <= count;
                  valid       <= 1'b1;
                  timeout     <= 1'b0;
                  count       <= '0;
               end else if (count == TIMEOUT_CYCLES) begin
                  state   <= IDLE;
                  timeout <= 1'b1;
                  count   <= '0;
               end else begin
                  count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               state <= IDLE;
               count <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: timestamp-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_period_meter;
   import period_meter_pkg::*;

   localparam int T = 16;

   logic                clk = 1'b0;
   logic                reset;
   logic                sig_in;
   logic [PM_WIDTH-1:0] half_period;
   logic                valid;
   logic                timeout;

   int n_chk  = 0;
   int n_pass = 0;

   period_meter #(.WIDTH(PM_WIDTH), .TIMEOUT_CYCLES(24'd16)) dut (
      .clk         (clk),
      .reset       (reset),
      .sig_in      (sig_in),
      .half_period (half_period),
      .valid       (valid),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Reference model: an input change sampled at cycle k acts at cycle k+2.
   // Captures are the distance between acting edges minus one; timeout fires
   // T+1 cycles after the last arming/capture edge if no edge arrives first.
   int          cyc    = 0;
   int          t_last = 0;
   bit          armed  = 0;
   bit          p1 = 0, p2 = 0, prev = 0, ev = 0;
   logic [31:0] e_hp    = 0;
   bit          e_valid = 0;
   bit          e_to    = 0;
   int          vcnt    = 0;
   int          hp_log[$];

   always @(posedge clk) begin
      cyc++;
      if (!reset) begin
         armed = 0; p1 = 0; p2 = 0; prev = 0;
         e_hp = 0; e_valid = 0; e_to = 0;
      end else begin
         ev   = p2;
         p2   = p1;
         p1   = (sig_in != prev);
         prev = sig_in;
         e_valid = 0;
         if (ev) begin
            if (armed) begin
               e_hp    = cyc - t_last - 1;
               e_valid = 1;
               e_to    = 0;
            end
            armed  = 1;
            t_last = cyc;
         end else if (armed && (cyc - t_last - 1) == T) begin
            armed = 0;
            e_to  = 1;
         end
      end
      #1;
      chk("valid", valid, e_valid);
      chk("timeout", timeout, e_to);
      chk("half_period", half_period, e_hp);
      if (valid === 1'b1) begin
         vcnt++;
         hp_log.push_back(int'(half_period));
      end
   end

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tog();
      sig_in = ~sig_in;
   endtask

   int v0;
   int n;

   initial begin
      reset  = 1'b0;
      sig_in = 1'b0;
      hold(3);
      chk("rst_hp", half_period, 0);
      chk("rst_valid", valid, 0);
      chk("rst_timeout", timeout, 0);
      reset = 1'b1;

      // Divider loopback, N = 4: six toggles, first only arms.
      v0 = vcnt;
      repeat (6) begin tog(); hold(5); end
      chk("div_valids", vcnt - v0, 5);
      chk("div_hp", half_period, 4);

      // Timeout: go quiet well past T+1 cycles.
      hold(20);
      chk("tmo_set", timeout, 1);
      chk("tmo_hp_kept", half_period, 4);
      v0 = vcnt;
      tog(); hold(4);
      chk("tmo_arm_no_valid", vcnt - v0, 0);
      chk("tmo_still_set", timeout, 1);
      hold(5); tog(); hold(4);
      chk("tmo_rearm_valid", vcnt - v0, 1);
      chk("tmo_rearm_hp", half_period, 8);
      chk("tmo_cleared", timeout, 0);

      // Minimum period: toggle every cycle.
      v0 = vcnt;
      for (int i = 0; i < 12; i++) begin
         tog(); hold(1);
         if (i == 6) begin
            chk("min_valid_high", valid, 1);
            chk("min_hp_zero", half_period, 0);
         end
      end
      hold(3);
      chk("min_valids", vcnt - v0, 12);

      // Edge/timeout tie: edges 17 cycles apart.
      hold(13); tog(); hold(4);
      chk("tie_hp", half_period, 16);
      chk("tie_timeout", timeout, 0);

      // Reset in the middle of an N = 9 measurement.
      tog(); hold(10); tog(); hold(5);
      reset = 1'b0;
      #1;
      chk("mid_rst_hp", half_period, 0);
      chk("mid_rst_valid", valid, 0);
      chk("mid_rst_timeout", timeout, 0);
      sig_in = 1'b1;
      hold(2);
      reset = 1'b1;
      v0 = vcnt;
      hold(4);
      chk("rel_arm_no_valid", vcnt - v0, 0);
      tog(); hold(10); tog(); hold(10); tog(); hold(4);
      chk("post_rst_hp", half_period, 9);

      // Unequal halves: 3 high, 7 low.
      repeat (3) begin tog(); hold(3); tog(); hold(7); end
      tog(); hold(4);
      n = hp_log.size();
      chk("uneq_a", hp_log[n-4], 2);
      chk("uneq_b", hp_log[n-3], 6);
      chk("uneq_c", hp_log[n-2], 2);
      chk("uneq_d", hp_log[n-1], 6);
      chk("uneq_timeout", timeout, 0);

      hold(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
